// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle RV32I main controller FSM with immediate-select and branch resolve
module mc_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [1:0] ALUOp,
  output logic       illegal
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, HALT
  } state_t;
  state_t state_q, state_d;
  logic   illegal_q;
  logic   pcw, irw, mw, rw;
  logic   unused_ok;
  assign unused_ok = &{1'b0, funct3[2:1]};
  // State register; illegal latches on the edge that enters HALT
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= state_t'(RESET_STATE);
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == HALT);
    end
  // Moore decode of the datapath controls and next state
  always_comb begin
    state_d   = state_q;
    pcw       = 1'b0;
    irw       = 1'b0;
    mw        = 1'b0;
    rw        = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    case (state_q)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irw       = mem_ready;
        pcw       = mem_ready;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        state_d = (op == 7'b0000011 || op == 7'b0100011) ? MEMADR :
                  (op == 7'b0110011) ? EXECUTER :
                  (op == 7'b0010011) ? EXECUTEI :
                  (op == 7'b1100011) ? BRANCH :
                  (op == 7'b1101111) ? JAL : HALT;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == 7'b0000011) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        rw        = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        AdrSrc  = 1'b1;
        mw      = 1'b1;
        state_d = mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        rw      = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        pcw     = Zero ^ funct3[0];
        state_d = FETCH;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pcw     = 1'b1;
        state_d = ALUWB;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end
  // Immediate format follows the opcode regardless of state
  always_comb
    ImmSrc = (op == 7'b0100011) ? 2'b01 :
             (op == 7'b1100011) ? 2'b10 :
             (op == 7'b1101111) ? 2'b11 : 2'b00;
  assign PCWrite  = reset_n & pcw;
  assign IRWrite  = reset_n & irw;
  assign MemWrite = reset_n & mw;
  assign RegWrite = reset_n & rw;
  assign illegal  = illegal_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed self-checking bench for the multicycle controller
module tb_mc_ctrl;
  logic       clk = 1'b0;
  logic       reset_n, Zero, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp;
  logic [15:0] obs;
  int checks = 0;
  int failures = 0;

  mc_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .RegWrite(RegWrite), .ALUOp(ALUOp), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ImmSrc, RegWrite, ALUOp, illegal};

  // pcw adr mw irw resultsrc srca srcb imm rw aluop illegal
  function automatic logic [15:0] ex(input logic pcw, adr, mw, irw,
                                     input logic [1:0] rs, sa, sb, imm,
                                     input logic rw, input logic [1:0] aop,
                                     input logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, aop, ill};
  endfunction

  task automatic chk(input string tag, input logic [15:0] e);
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; mem_ready = 1'b1; Zero = 1'b0; funct3 = 3'b000; op = 7'b0110011;
    #12;
    chk("rst_hold", ex(0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,2'b00,0));
    reset_n = 1'b1;
    #1;
    chk("rst_fetch", ex(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,2'b00,0));
    // add
    tick; chk("add_dec", ex(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,2'b00,0));
    tick; chk("add_exe", ex(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,2'b10,0));
    tick; chk("add_wb",  ex(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,2'b00,0));
    // addi
    op = 7'b0010011;
    tick; chk("addi_f",   ex(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,2'b00,0));
    tick; chk("addi_dec", ex(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,2'b00,0));
    tick; chk("addi_exe", ex(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,2'b10,0));
    tick; chk("addi_wb",  ex(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,2'b00,0));
    // lw with two stall cycles in MEMREAD
    op = 7'b0000011;
    tick; chk("lw_f",   ex(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,2'b00,0));
    tick; chk("lw_dec", ex(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,2'b00,0));
    tick; chk("lw_adr", ex(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,2'b00,0));
    tick; mem_ready = 1'b0; #1;
    chk("lw_rd0", ex(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,2'b00,0));
    tick; chk("lw_rd1", ex(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,2'b00,0));
    tick; mem_ready = 1'b1; #1;
    chk("lw_rd2", ex(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,2'b00,0));
    tick; chk("lw_wb", ex(0,0,0,0,2'b01,2'b00,2'b00,2'b00,1,2'b00,0));
    // sw, no stalls
    op = 7'b0100011;
    tick; chk("sw_f",   ex(1,0,0,1,2'b10,2'b00,2'b10,2'b01,0,2'b00,0));
    tick; chk("sw_dec", ex(0,0,0,0,2'b00,2'b01,2'b01,2'b01,0,2'b00,0));
    tick; chk("sw_adr", ex(0,0,0,0,2'b00,2'b10,2'b01,2'b01,0,2'b00,0));
    tick; chk("sw_wr",  ex(0,1,1,0,2'b00,2'b00,2'b00,2'b01,0,2'b00,0));
    tick; chk("sw_done", ex(1,0,0,1,2'b10,2'b00,2'b10,2'b01,0,2'b00,0));
    // second sw aborted by reset while stalled in MEMWRITE
    tick; tick; tick; mem_ready = 1'b0; #1;
    chk("sw2_wr", ex(0,1,1,0,2'b00,2'b00,2'b00,2'b01,0,2'b00,0));
    reset_n = 1'b0; #1;
    chk("sw2_rst", ex(0,0,0,0,2'b10,2'b00,2'b10,2'b01,0,2'b00,0));
    #1; reset_n = 1'b1; #1;
    chk("fetch_stall0", ex(0,0,0,0,2'b10,2'b00,2'b10,2'b01,0,2'b00,0));
    tick; chk("fetch_stall1", ex(0,0,0,0,2'b10,2'b00,2'b10,2'b01,0,2'b00,0));
    // beq taken
    op = 7'b1100011; funct3 = 3'b000; Zero = 1'b1; mem_ready = 1'b1; #1;
    chk("beq_f", ex(1,0,0,1,2'b10,2'b00,2'b10,2'b10,0,2'b00,0));
    tick; chk("beq_dec", ex(0,0,0,0,2'b00,2'b01,2'b01,2'b10,0,2'b00,0));
    tick; chk("beq_br",  ex(1,0,0,0,2'b00,2'b10,2'b00,2'b10,0,2'b01,0));
    // bne not taken, then taken when Zero falls
    funct3 = 3'b001;
    tick; tick; tick; chk("bne_br_z1", ex(0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,2'b01,0));
    Zero = 1'b0; #1;
    chk("bne_br_z0", ex(1,0,0,0,2'b00,2'b10,2'b00,2'b10,0,2'b01,0));
    // jal
    op = 7'b1101111;
    tick; chk("jal_f",   ex(1,0,0,1,2'b10,2'b00,2'b10,2'b11,0,2'b00,0));
    tick; chk("jal_dec", ex(0,0,0,0,2'b00,2'b01,2'b01,2'b11,0,2'b00,0));
    tick; chk("jal_j",   ex(1,0,0,0,2'b00,2'b01,2'b10,2'b11,0,2'b00,0));
    tick; chk("jal_wb",  ex(0,0,0,0,2'b00,2'b00,2'b00,2'b11,1,2'b00,0));
    tick; chk("jal_back", ex(1,0,0,1,2'b10,2'b00,2'b10,2'b11,0,2'b00,0));
    // illegal opcode
    op = 7'b0000000;
    tick; chk("ill_dec", ex(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,2'b00,0));
    for (int i = 0; i < 11; i++) begin
      tick; chk("ill_halt", ex(0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,2'b00,1));
    end
    reset_n = 1'b0; #1;
    chk("ill_rst", ex(0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,2'b00,0));
    #2; reset_n = 1'b1; #1;
    chk("ill_fetch", ex(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,2'b00,0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle main controller for the RV32I core. Sequences the shared ALU, memory port, instruction register and register file over several cycles per instruction.
- Drives ALUOp into the existing ALU decoder, which produces ALUControl from ALUOp, funct3 and funct7b5.
- Moore FSM with memory-ready stalls plus a combinational immediate-select and branch-resolve path.

Parameters:
- RESET_STATE, FETCH, state entered on reset (fixed encoding; kept as a parameter for bring-up only).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  7  opcode from the instruction register.
- funct3  in  3  funct3 from the instruction register.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  unified memory completes the current access this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction-register (and OldPC) enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU operand A select: 00 = PC, 01 = OldPC, 10 = rd1.
- ALUSrcB  out  2  ALU operand B select: 00 = rd2, 01 = ImmExt, 10 = constant 4.
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- RegWrite  out  1  register-file write enable.
- ALUOp  out  2  00 = add, 01 = subtract, 10 = decode from funct3/funct7.
- illegal  out  1  sticky illegal-opcode flag.

Behaviour:
- Reset: asynchronous on reset_n low, state <= FETCH, illegal <= 0. Outputs are the FETCH decode; while reset_n is low, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0. Reset mid-instruction abandons it; no partial writes after the reset edge.
- Outputs not listed for a state are 0. ALUSrcA, ALUSrcB, ResultSrc and ALUOp read 00 when unlisted.
- States, outputs and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=mem_ready and PCWrite=mem_ready (PC+4). Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by opcode:
    - 0000011 or 0100011 -> MEMADR.
    - 0110011 -> EXECUTER.
    - 0010011 -> EXECUTEI.
    - 1100011 -> BRANCH.
    - 1101111 -> JAL.
    - Any other opcode -> HALT.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: op=0000011 -> MEMREAD, otherwise -> MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Holds until mem_ready=1, then -> MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready=1, then -> FETCH. The memory samples the write on the mem_ready cycle.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. PCWrite = Zero XOR funct3[0] (beq taken on Zero=1, bne taken on Zero=0) -> FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 -> ALUWB (rd <= OldPC+4).
  - HALT: sets illegal=1 on entry. No enables asserted. Stays in HALT until reset.
- ImmSrc: combinational from op in every state.
  - 0100011 -> 01.
  - 1100011 -> 10.
  - 1101111 -> 11.
  - Otherwise -> 00.
- Latency in cycles, with mem_ready=1 every cycle:
  - lw = 5.
  - sw = 4.
  - R/I ALU = 4.
  - branch = 3.
  - jal = 4.
  - Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds 1.
- The FSM never asserts MemWrite and RegWrite in the same cycle. IRWrite is asserted only in FETCH.

Test Plan:
- Reset: drive reset_n low mid-MEMWRITE -> MemWrite drops immediately. After release, FETCH; with mem_ready=1 the first edge gives IRWrite=PCWrite=1, ALUSrcB=10.
- add (op=0110011), mem_ready=1 throughout -> states FETCH, DECODE, EXECUTER, ALUWB; ALUOp=10 in EXECUTER; RegWrite=1 only in the 4th cycle, ResultSrc=00.
- lw with mem_ready low for 2 cycles in MEMREAD -> 7 cycles total; AdrSrc=1 across all MEMREAD cycles; RegWrite=1 with ResultSrc=01 in the final cycle.
- beq/bne: funct3=000 with Zero=1, then funct3=001 with Zero=1 -> PCWrite=1, then PCWrite=0; ALUOp=01 in BRANCH both times.
- jal (op=1101111) -> ImmSrc=11; PCWrite=1 in JAL; RegWrite=1 in the next cycle; back to FETCH after 4 cycles.
- op=0000000 -> HALT after DECODE; illegal=1; all enables 0 for 10+ cycles until reset_n is pulsed low, which clears illegal.
